// File: rtl/data_mem_wait.sv
// Data memory behind LATENCY wait states: a request accepted in cycle 0 answers with a rsp_valid pulse in cycle LATENCY+1.
// mem_stall holds the pipeline from acceptance through the access edge; misaligned accesses keep the timing but never write.
module data_mem_wait #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        mem_stall,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        misalign_err
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              wr_q, wr_d;
    logic [ADDR_W+1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              misalign_err_q, misalign_err_d;

    logic [31:0]       mem [DEPTH];

    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        lane;
    logic              misal;
    logic              access;
    logic [3:0]        be;
    logic [31:0]       wr_dat;
    logic [31:0]       rd_word;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_data;
    logic              unused_addr_hi;

    // Address bits above the word index wrap the array.
    assign unused_addr_hi = ^req_addr[31:ADDR_W+2];

    assign word_idx = addr_q[ADDR_W+1:2];
    assign lane     = addr_q[1:0];
    assign access   = (state_q == BUSY) && (cnt_q == 4'd0);
    assign rd_word  = mem[word_idx];
    assign rd_byte  = rd_word[{lane, 3'b000} +: 8];
    assign rd_half  = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        misal  = 1'b0;
        be     = 4'b0000;
        wr_dat = 32'd0;
        case (size_q)
            2'b00: begin
                be     = 4'b0001 << lane;
                wr_dat = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                misal  = lane[0];
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wr_dat = {2{wdata_q[15:0]}};
            end
            2'b10: begin
                misal  = |lane;
                be     = 4'b1111;
                wr_dat = wdata_q;
            end
            default: misal = 1'b1;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00:   load_data = uns_q ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_data = uns_q ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        wr_d           = wr_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        size_d         = size_q;
        uns_d          = uns_q;
        rsp_valid_d    = 1'b0;
        misalign_err_d = 1'b0;
        rsp_rdata_d    = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    wr_d    = req_write;
                    addr_d  = req_addr[ADDR_W+1:0];
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = 4'(cnt_q - 4'd1);
                end else begin
                    state_d        = RESP;
                    rsp_valid_d    = 1'b1;
                    misalign_err_d = misal;
                    rsp_rdata_d    = (wr_q || misal) ? 32'd0 : load_data;
                end
            end
            // The pipeline slot that issued this request is still presenting it.
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= 4'd0;
            wr_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= 32'd0;
            size_q         <= 2'b00;
            uns_q          <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_rdata_q    <= 32'd0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            wr_q           <= wr_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            size_q         <= size_d;
            uns_q          <= uns_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_rdata_q    <= rsp_rdata_d;
            misalign_err_q <= misalign_err_d;
        end
    end

    // Array is not reset; reset forces IDLE, so an aborted store never reaches this edge.
    always_ff @(posedge clk) begin
        if (access && wr_q && !misal) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_dat[8*i +: 8];
                end
            end
        end
    end

    assign mem_stall    = ((state_q == IDLE) && req_valid) || (state_q == BUSY);
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign misalign_err = misalign_err_q;
endmodule

// File: tb/tb_data_mem_wait.sv
// Drives three differently parameterised data_mem_wait instances with directed and random requests,
// checking every cycle against a transaction-level memory model.
module tb_data_mem_wait;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endfunction

    function automatic int cfg_aw(input int g);
        return (g == 0) ? 4 : (g == 1) ? 6 : 10;
    endfunction

    function automatic int cfg_lat(input int g);
        return (g == 0) ? 2 : (g == 1) ? 1 : 15;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : gen_blk
        localparam int AW    = cfg_aw(g);
        localparam int LAT   = cfg_lat(g);
        localparam int DEPTH = 1 << AW;
        // Random addresses stay inside word indices 0..15 (upper bits still random for wrap).
        localparam logic [31:0] WIN_MASK = ((32'd1 << (AW + 2)) - 32'd1) & ~32'h3F;

        logic        rst, req_valid, req_write, req_unsigned;
        logic [31:0] req_addr, req_wdata;
        logic [1:0]  req_size;
        logic        mem_stall, rsp_valid, misalign_err;
        logic [31:0] rsp_rdata;
        bit          done = 1'b0;

        data_mem_wait #(.ADDR_W(AW), .LATENCY(LAT)) dut (
            .clk(clk), .rst(rst), .req_valid(req_valid), .req_write(req_write),
            .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
            .req_unsigned(req_unsigned), .mem_stall(mem_stall), .rsp_valid(rsp_valid),
            .rsp_rdata(rsp_rdata), .misalign_err(misalign_err)
        );

        // Model: ph is the cycle number since acceptance (-1 when nothing outstanding).
        logic [31:0] mem_m [DEPTH];
        int          ph = -1;
        logic [31:0] hold_rd = 32'd0;
        bit          c_wr, c_uns;
        logic [31:0] c_addr, c_wdata;
        logic [1:0]  c_size;
        logic [31:0] m_word, m_res, m_mask, m_v;
        int          m_nb, m_off, m_idx;
        bit          m_mis;

        always @(negedge clk) begin
            if (rst) begin
                chk($sformatf("b%0d rst stall", g), 32'(mem_stall), 32'(req_valid));
                chk($sformatf("b%0d rst rsp_valid", g), 32'(rsp_valid), 32'd0);
                chk($sformatf("b%0d rst rdata", g), rsp_rdata, 32'd0);
                chk($sformatf("b%0d rst err", g), 32'(misalign_err), 32'd0);
                ph      = -1;
                hold_rd = 32'd0;
            end else if (ph == LAT + 1) begin
                m_nb   = 1 << c_size;
                m_off  = int'(c_addr % 4);
                m_idx  = int'((c_addr / 4) % DEPTH);
                m_mis  = (c_size == 2'b11) || ((c_addr % m_nb) != 0);
                m_word = mem_m[m_idx];
                m_res  = 32'd0;
                if (!m_mis && c_wr) begin
                    for (int i = 0; i < 4; i++) begin
                        if (i >= m_off && i < m_off + m_nb)
                            m_word = (m_word & ~(32'hFF << (8 * i)))
                                   | (((c_wdata >> (8 * (i - m_off))) & 32'hFF) << (8 * i));
                    end
                    mem_m[m_idx] = m_word;
                end else if (!m_mis) begin
                    if (m_nb == 4) m_res = m_word;
                    else begin
                        m_mask = 32'((64'd1 << (8 * m_nb)) - 64'd1);
                        m_v    = (m_word >> (8 * m_off)) & m_mask;
                        if (!c_uns && m_v > (m_mask >> 1)) m_v = m_v | ~m_mask;
                        m_res = m_v;
                    end
                end
                chk($sformatf("b%0d resp stall", g), 32'(mem_stall), 32'd0);
                chk($sformatf("b%0d resp rsp_valid", g), 32'(rsp_valid), 32'd1);
                chk($sformatf("b%0d resp rdata", g), rsp_rdata, m_res);
                chk($sformatf("b%0d resp err", g), 32'(misalign_err), 32'(m_mis));
                hold_rd = m_res;
                ph      = -1;
            end else begin
                chk($sformatf("b%0d stall", g), 32'(mem_stall), (ph >= 1) ? 32'd1 : 32'(req_valid));
                chk($sformatf("b%0d rsp_valid", g), 32'(rsp_valid), 32'd0);
                chk($sformatf("b%0d rdata hold", g), rsp_rdata, hold_rd);
                if (ph >= 1) ph++;
                else if (req_valid) begin
                    c_wr = req_write; c_addr = req_addr; c_wdata = req_wdata;
                    c_size = req_size; c_uns = req_unsigned;
                    ph = 1;
                end
            end
        end

        task automatic scramble(input bit vld);
            req_valid    = vld;
            req_write    = 1'($urandom);
            req_addr     = $urandom;
            req_wdata    = $urandom;
            req_size     = 2'($urandom);
            req_unsigned = 1'($urandom);
        endtask

        // Entered and left just after a rising edge; request inputs garbled while outstanding.
        task automatic xact(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [1:0] size, input bit uns, output logic [31:0] rd,
                            output bit err, output int lat, output int stalls);
            req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
            req_size = size; req_unsigned = uns;
            lat = -1; stalls = 0; rd = 32'd0; err = 1'b0;
            for (int c = 0; c < LAT + 6 && lat < 0; c++) begin
                @(negedge clk);
                if (mem_stall) stalls++;
                if (rsp_valid) begin lat = c; rd = rsp_rdata; err = misalign_err; end
                @(posedge clk); #1;
                if (lat < 0) scramble(1'($urandom));
            end
            req_valid = 1'b0;
        endtask

        task automatic run(input string nm, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input bit uns,
                           input logic [31:0] exp_rd, input bit exp_err);
            logic [31:0] rd; bit err; int lat, st;
            xact(wr, addr, wdata, size, uns, rd, err, lat, st);
            chk($sformatf("b%0d %s latency", g, nm), 32'(lat), 32'(LAT + 1));
            chk($sformatf("b%0d %s stall cycles", g, nm), 32'(st), 32'(LAT + 1));
            chk($sformatf("b%0d %s rdata", g, nm), rd, exp_rd);
            chk($sformatf("b%0d %s err", g, nm), 32'(err), 32'(exp_err));
        endtask

        initial begin
            logic [31:0] rd; bit err; int lat, st;
            rst = 1'b1;
            scramble(1'b0);
            repeat (2) @(posedge clk);
            #1;
            chk($sformatf("b%0d reset rdata", g), rsp_rdata, 32'd0);
            chk($sformatf("b%0d reset rsp_valid", g), 32'(rsp_valid), 32'd0);
            rst = 1'b0;
            for (int i = 0; i < 16; i++) xact(1'b1, 32'(i * 4), 32'd0, 2'b10, 1'b0, rd, err, lat, st);

            run("st word", 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0, 32'd0, 1'b0);
            run("ld word", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
            run("clr word", 1'b1, 32'h10, 32'd0, 2'b10, 1'b0, 32'd0, 1'b0);
            run("st byte", 1'b1, 32'h13, 32'h80, 2'b00, 1'b0, 32'd0, 1'b0);
            run("ld byte s", 1'b0, 32'h13, 32'd0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
            run("ld byte u", 1'b0, 32'h13, 32'd0, 2'b00, 1'b1, 32'h00000080, 1'b0);
            run("ld word b", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'h80000000, 1'b0);
            run("ld half mis", 1'b0, 32'h11, 32'd0, 2'b01, 1'b0, 32'd0, 1'b1);
            run("st word mis", 1'b1, 32'h12, 32'h12345678, 2'b10, 1'b0, 32'd0, 1'b1);
            run("ld size3", 1'b0, 32'h10, 32'd0, 2'b11, 1'b0, 32'd0, 1'b1);
            run("ld after mis", 1'b0, 32'h10, 32'd0, 2'b10, 1'b0, 32'h80000000, 1'b0);
            run("st half", 1'b1, 32'h16, 32'h5A5A8001, 2'b01, 1'b0, 32'd0, 1'b0);
            run("ld half s", 1'b0, 32'h16, 32'd0, 2'b01, 1'b0, 32'hFFFF8001, 1'b0);
            run("ld half u", 1'b0, 32'h16, 32'd0, 2'b01, 1'b1, 32'h00008001, 1'b0);
            run("ld word h", 1'b0, 32'h14, 32'd0, 2'b10, 1'b0, 32'h80010000, 1'b0);
            run("st wrap", 1'b1, 32'd1 << (AW + 2), 32'h11111111, 2'b10, 1'b0, 32'd0, 1'b0);
            run("ld wrap", 1'b0, 32'h0, 32'd0, 2'b10, 1'b0, 32'h11111111, 1'b0);
            run("st prior", 1'b1, 32'h20, 32'h12345678, 2'b10, 1'b0, 32'd0, 1'b0);
            run("ld prior", 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 32'h12345678, 1'b0);

            // Store aborted by reset in its first BUSY cycle.
            req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hAAAAAAAA;
            req_size = 2'b10; req_unsigned = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            #1;
            chk($sformatf("b%0d abort rdata", g), rsp_rdata, 32'd0);
            chk($sformatf("b%0d abort rsp_valid", g), 32'(rsp_valid), 32'd0);
            chk($sformatf("b%0d abort stall", g), 32'(mem_stall), 32'd1);
            req_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            for (int c = 0; c < LAT + 3; c++) begin
                @(negedge clk);
                chk($sformatf("b%0d abort no rsp", g), 32'(rsp_valid), 32'd0);
            end
            @(posedge clk); #1;
            run("ld abort", 1'b0, 32'h20, 32'd0, 2'b10, 1'b0, 32'h12345678, 1'b0);

            for (int n = 0; n < 120; n++) begin
                repeat ($urandom_range(2, 0)) begin
                    scramble(1'b0);
                    @(posedge clk); #1;
                end
                if (n % 30 == 29) begin
                    rst = 1'b1;
                    @(posedge clk); #1;
                    rst = 1'b0;
                end
                xact(1'($urandom), $urandom & ~WIN_MASK, $urandom, 2'($urandom),
                     1'($urandom), rd, err, lat, st);
                chk($sformatf("b%0d rand latency", g), 32'(lat), 32'(LAT + 1));
            end
            done = 1'b1;
        end
    end

    initial begin
        for (int t = 0; t < 60000; t++) begin
            #10;
            if (gen_blk[0].done && gen_blk[1].done && gen_blk[2].done) break;
        end
        chk("blocks finished", {29'd0, gen_blk[2].done, gen_blk[1].done, gen_blk[0].done}, 32'd7);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/data_mem_wait.md
DATA_MEM_WAIT -- requirements
Module: data_mem_wait

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, number of word-address bits; depth is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles before access; legal range 1..15.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1, MEM-stage access request (MemRead or MemWrite).
REQ-006 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_addr, input, 32, byte address.
REQ-008 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-009 SHALL have port req_size, input, 2, 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 SHALL have port req_unsigned, input, 1, 1 = zero-extend loads, 0 = sign-extend.
REQ-011 SHALL have port mem_stall, output, 1, freezes the pipeline while an access is outstanding.
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-013 SHALL have port rsp_rdata, output, 32, extended load data.
REQ-014 SHALL have port misalign_err, output, 1, access rejected; qualified by rsp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-016 In IDLE with req_valid=1: SHALL capture write, addr, wdata, size and unsigned; load counter with LATENCY-1; go to BUSY.
REQ-017 mem_stall SHALL be combinational: 1 when (IDLE and req_valid) or BUSY; 0 in RESP.
REQ-018 In BUSY with counter>0: SHALL decrement the counter each cycle.
REQ-019 In BUSY with counter=0: SHALL perform the access on that edge and go to RESP.
REQ-020 In RESP: rsp_valid SHALL be 1 for exactly one cycle; SHALL return to IDLE ignoring req_valid, because the request is still the same pipeline slot.
REQ-021 Latency: request in cycle 0 -> rsp_valid in cycle LATENCY+1; mem_stall high in cycles 0..LATENCY.
REQ-022 Back-to-back: a new request SHALL be accepted only in IDLE, minimum spacing LATENCY+2 cycles.
REQ-023 Word index SHALL be addr[ADDR_W+1:2]; upper address bits ignored (wrap modulo depth).
REQ-024 Stores SHALL write byte lanes only:
  - byte: lane addr[1:0], data wdata[7:0]
  - half: lanes addr[1]*2 and addr[1]*2+1, data wdata[15:0]
  - word: all four lanes
REQ-025 Loads SHALL select byte or halfword by addr[1:0], then sign- or zero-extend per req_unsigned; word loads are unmodified.
REQ-026 Misalignment (half with addr[0]=1, word with addr[1:0]!=0, or size 11) SHALL apply the same timing, but:
  - no memory write
  - rsp_rdata=0
  - misalign_err=1 during RESP
REQ-027 rsp_rdata SHALL hold its last value outside RESP; rsp_rdata SHALL be 0 after a store response.
REQ-028 Changes on request inputs while in BUSY or RESP SHALL have no effect.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, counter=0, rsp_valid=0, rsp_rdata=0 and misalign_err=0; mem_stall then follows req_valid.
REQ-030 Memory array contents SHALL NOT be reset.
REQ-031 A store aborted by reset before its access edge SHALL leave memory unchanged.

Verification
REQ-032 LATENCY=2, word store 0xDEADBEEF @0x10, then word load @0x10 -> each request: stall 3 cycles, rsp_valid in cycle 3, load rdata 0xDEADBEEF.
REQ-033 Byte store 0x80 @0x13 over 0x00000000, then load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080; load word -> 0x80000000.
REQ-034 Halfword load @0x11 -> misalign_err=1 with rsp_valid, rsp_rdata=0, memory unchanged, same latency.
REQ-035 ADDR_W=4, store 0x11111111 @0x40 -> load @0x00 returns 0x11111111 (wrap).
REQ-036 rst pulse in the first BUSY cycle of a store 0xAAAAAAAA @0x20 -> outputs 0 immediately, no rsp_valid, later load @0x20 returns the prior value.
REQ-037 LATENCY=1 and LATENCY=15 sweep -> rsp_valid exactly LATENCY+1 cycles after acceptance, single-cycle pulse.
